fb_wr_sched: RTL and testbench

Frame-buffer write scheduler sitting between the pixel producers and the write port of the frame-buffer BRAM inside `mem_top`. It grants the single BRAM write port to one of two pixel streams: s0, the live video-processing pipeline, and s1, the test-pattern/overlay source. It aligns writes to start-of-frame and generates the linear write address 0..FRAME_PIXELS-1. Source switching and freeze-frame requests take effect only at frame boundaries, so the VGA side never displays a torn frame.

---
 rtl/fb_wr_sched.sv | 142 ++++++++++++++
 tb/tb_fb_wr_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fb_wr_sched.sv
// Frame-buffer write scheduler: grants the BRAM write port to one of two pixel streams, switching only at frame boundaries.
// Optional statistics counters are enabled by defining FB_WR_SCHED_STATS_EN.
module fb_wr_sched #(
  parameter int DW           = 12,
  parameter int AW           = 19,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_s0_valid,
  output logic          o_s0_ready,
  input  logic [DW-1:0] i_s0_data,
  input  logic          i_s0_sof,
  input  logic          i_s1_valid,
  output logic          o_s1_ready,
  input  logic [DW-1:0] i_s1_data,
  input  logic          i_s1_sof,
  input  logic          i_sel,
  input  logic          i_freeze,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_grant,
  output logic          o_frame_done,
  output logic          o_resync,
  output logic [15:0]   o_frame_cnt,
  output logic [7:0]    o_resync_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, STREAM, FROZEN} state_t;

  localparam logic [AW-1:0] LAST = AW'(FRAME_PIXELS - 1);

  state_t        state;
  logic [AW-1:0] addr;
  logic          beat_valid;
  logic          beat_sof;
  logic [DW-1:0] beat_data;
  logic          beat;
  logic          resync_ev;
  logic          done_ev;

  assign o_s0_ready = (state != IDLE) && !o_grant;
  assign o_s1_ready = (state != IDLE) &&  o_grant;

  always_comb begin
    beat_valid = o_grant ? i_s1_valid : i_s0_valid;
    beat_sof   = o_grant ? i_s1_sof   : i_s0_sof;
    beat_data  = o_grant ? i_s1_data  : i_s0_data;
    beat       = beat_valid && (state != IDLE);
    // Resync takes priority over frame end: an SOF beat is always written at address 0.
    resync_ev  = (state == STREAM) && beat && beat_sof && (addr != '0);
    done_ev    = (state == STREAM) && beat && !resync_ev && (addr == LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= IDLE;
      addr         <= '0;
      o_grant      <= 1'b0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_frame_done <= 1'b0;
      o_resync     <= 1'b0;
    end else begin
      o_we         <= 1'b0;
      o_frame_done <= 1'b0;
      o_resync     <= 1'b0;
      case (state)
        IDLE: begin
          state   <= SYNC;
          o_grant <= i_sel;
        end
        SYNC: begin
          if (beat && beat_sof) begin
            o_we    <= 1'b1;
            o_waddr <= '0;
            o_wdata <= beat_data;
            addr    <= AW'(1);
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (beat) begin
            o_we    <= 1'b1;
            o_wdata <= beat_data;
            if (resync_ev) begin
              o_waddr  <= '0;
              addr     <= AW'(1);
              o_resync <= 1'b1;
            end else begin
              o_waddr <= addr;
              if (done_ev) begin
                addr         <= '0;
                o_frame_done <= 1'b1;
                if (i_freeze) begin
                  state <= FROZEN;
                end else begin
                  state   <= SYNC;
                  o_grant <= i_sel;
                end
              end else begin
                addr <= addr + AW'(1);
              end
            end
          end
        end
        FROZEN: begin
          if (!i_freeze) begin
            state   <= SYNC;
            o_grant <= i_sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_WR_SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  resync_cnt;

  // Counters step together with the pulse they count, so they read updated during the pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      frame_cnt  <= '0;
      resync_cnt <= '0;
    end else begin
      if (done_ev) frame_cnt <= frame_cnt + 16'd1;
      if (resync_ev && (resync_cnt != '1)) resync_cnt <= resync_cnt + 8'd1;
    end
  end

  assign o_frame_cnt  = frame_cnt;
  assign o_resync_cnt = resync_cnt;
`else
  assign o_frame_cnt  = '0;
  assign o_resync_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_wr_sched.sv
// Scoreboard bench for fb_wr_sched, using a reduced frame size to keep runs short.
module tb_fb_wr_sched;

  localparam int DW = 12;
  localparam int AW = 19;
  localparam int F  = 1200;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_s0_valid, i_s1_valid;
  logic          o_s0_ready, o_s1_ready;
  logic [DW-1:0] i_s0_data, i_s1_data;
  logic          i_s0_sof, i_s1_sof;
  logic          i_sel, i_freeze;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_grant, o_frame_done, o_resync;
  logic [15:0]   o_frame_cnt;
  logic [7:0]    o_resync_cnt;

  fb_wr_sched #(.DW(DW), .AW(AW), .FRAME_PIXELS(F)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_s0_valid(i_s0_valid), .o_s0_ready(o_s0_ready), .i_s0_data(i_s0_data), .i_s0_sof(i_s0_sof),
    .i_s1_valid(i_s1_valid), .o_s1_ready(o_s1_ready), .i_s1_data(i_s1_data), .i_s1_sof(i_s1_sof),
    .i_sel(i_sel), .i_freeze(i_freeze),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_grant(o_grant),
    .o_frame_done(o_frame_done), .o_resync(o_resync),
    .o_frame_cnt(o_frame_cnt), .o_resync_cnt(o_resync_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          addr;
    logic [11:0] data;
    bit          fd;
    bit          rs;
    int          fc;
    int          rc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   exp_grant = 1'b0;
  int   exp_fc = 0;
  int   exp_rc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_we === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr %0d data %0h expected no write at %0t", o_waddr, o_wdata, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("waddr", 32'(o_waddr), 32'(e.addr));
        chk("wdata", 32'(o_wdata), 32'(e.data));
        chk("frame_done", 32'(o_frame_done), 32'(e.fd));
        chk("resync", 32'(o_resync), 32'(e.rs));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(e.fc));
        chk("resync_cnt", 32'(o_resync_cnt), 32'(e.rc));
      end
    end else begin
      chk("pulse_without_we", 32'(o_frame_done === 1'b1 || o_resync === 1'b1), 32'd0);
    end
  end

  // Present one beat from the granted source while the other source offers junk.
  task automatic beat(input bit src, input bit sof, input logic [11:0] d,
                      input bit wr, input int a, input bit fd, input bit rs);
    exp_t e;
    i_s0_valid = 1'b1;
    i_s1_valid = 1'b1;
    i_s0_sof   = src ? 1'b1 : sof;
    i_s1_sof   = src ? sof : 1'b1;
    i_s0_data  = src ? 12'hFFF : d;
    i_s1_data  = src ? d : 12'hFFF;
    chk("grant", 32'(o_grant), 32'(exp_grant));
    chk("ready_granted", 32'(src ? o_s1_ready : o_s0_ready), 32'd1);
    chk("ready_other", 32'(src ? o_s0_ready : o_s1_ready), 32'd0);
    if (wr) begin
      if (fd) exp_fc++;
      if (rs && exp_rc < 255) exp_rc++;
      e.addr = a;
      e.data = d;
      e.fd   = fd;
      e.rs   = rs;
`ifdef FB_WR_SCHED_STATS_EN
      e.fc   = exp_fc & 16'hFFFF;
      e.rc   = exp_rc;
`else
      e.fc   = 0;
      e.rc   = 0;
`endif
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_cycle();
    i_s0_valid = 1'b0;
    i_s1_valid = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_waddr", 32'(o_waddr), 32'd0);
    chk("rst_wdata", 32'(o_wdata), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_s0_ready", 32'(o_s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(o_s1_ready), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    chk("rst_resync", 32'(o_resync), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_resync_cnt", 32'(o_resync_cnt), 32'd0);
  endtask

  initial begin
    i_rstn = 1'b0; i_sel = 1'b0; i_freeze = 1'b0;
    i_s0_valid = 1'b0; i_s1_valid = 1'b0;
    i_s0_sof = 1'b0; i_s1_sof = 1'b0;
    i_s0_data = '0; i_s1_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_values();
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Pre-SOF garbage, then a full frame from s0.
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 12'(i + 1), 1'b0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 12'hABC, 1'b1, 0, 1'b0, 1'b0);
    for (int a = 1; a < F; a++) beat(1'b0, 1'b0, 12'($urandom), 1'b1, a, a == F - 1, 1'b0);

    // Early SOF at beat 1000, then a source switch requested mid-frame.
    beat(1'b0, 1'b1, 12'h111, 1'b1, 0, 1'b0, 1'b0);
    for (int a = 1; a < 1000; a++) beat(1'b0, 1'b0, 12'($urandom), 1'b1, a, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 12'h5A5, 1'b1, 0, 1'b0, 1'b1);
    for (int a = 1; a < F; a++) begin
      if (a == 100) i_sel = 1'b1;
      beat(1'b0, 1'b0, 12'($urandom), 1'b1, a, a == F - 1, 1'b0);
    end
    exp_grant = 1'b1;

    // Frame from s1 with freeze raised on the last pixel.
    beat(1'b1, 1'b1, 12'h222, 1'b1, 0, 1'b0, 1'b0);
    for (int a = 1; a < F; a++) begin
      if (a == F - 1) i_freeze = 1'b1;
      beat(1'b1, 1'b0, 12'($urandom), 1'b1, a, a == F - 1, 1'b0);
    end
    for (int i = 0; i < 1000; i++) beat(1'b1, i[0], 12'($urandom), 1'b0, 0, 1'b0, 1'b0);
    i_freeze = 1'b0;
    beat(1'b1, 1'b1, 12'h333, 1'b0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 12'h334, 1'b0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 12'h335, 1'b0, 0, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 12'h444, 1'b1, 0, 1'b0, 1'b0);
    for (int a = 1; a <= 500; a++) beat(1'b1, 1'b0, 12'($urandom), 1'b1, a, 1'b0, 1'b0);

    // Mid-frame reset discards the partial frame.
    i_s0_valid = 1'b0;
    i_s1_valid = 1'b0;
    i_rstn = 1'b0;
    @(posedge i_clk);
    #1;
    chk_reset_values();
    exp_grant = 1'b0;
    exp_fc = 0;
    exp_rc = 0;
    i_sel = 1'b0;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    beat(1'b0, 1'b0, 12'h0F0, 1'b0, 0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 12'h123, 1'b1, 0, 1'b0, 1'b0);
    for (int a = 1; a <= 3; a++) beat(1'b0, 1'b0, 12'(a * 17), 1'b1, a, 1'b0, 1'b0);

    repeat (3) idle_cycle();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
